// File: rtl/seven_seg_frame_driver_pkg.sv
// seven_seg_frame_driver_pkg: shared 7-segment constants (active-low gfedcba patterns, scan states, blank levels)
package seven_seg_frame_driver_pkg;
  localparam logic ST_BLANK = 1'b0;
  localparam logic ST_ON = 1'b1;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low 7-segment pattern
module hex_to_seg
  import seven_seg_frame_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/seven_seg_frame_driver.sv
// seven_seg_frame_driver: 4-digit multiplexed 7-segment scan with dead-time blanking,
// leading-zero suppression and frame-boundary commit of loaded values
module seven_seg_frame_driver
  import seven_seg_frame_driver_pkg::*;
#(
  parameter int DIGIT_CYCLES = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  logic [CW-1:0] c, c_n;
  logic [1:0] d, d_n;
  logic st, st_n;
  logic [15:0] disp, pend_data;
  logic [3:0] disp_dp, pend_dp;
  logic [3:0] nib, an_n;
  logic [6:0] seg_dec, seg_n;
  logic dp_n, fd_n, sup, on, last, commit;

  hex_to_seg u_dec (.hex(nib), .seg(seg_dec));

  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
      d <= '0;
      st <= ST_BLANK;
      an <= AN_OFF;
      seg <= SEG_OFF;
      dp <= 1'b1;
      frame_done <= 1'b0;
      pending <= 1'b0;
      disp <= '0;
      disp_dp <= '0;
      pend_data <= '0;
      pend_dp <= '0;
    end else begin
      c <= c_n;
      d <= d_n;
      st <= st_n;
      an <= an_n;
      seg <= seg_n;
      dp <= dp_n;
      frame_done <= fd_n;
      if (commit) {disp, disp_dp} <= {pend_data, pend_dp};
      if (load) {pend_data, pend_dp} <= {data_in, dp_in};
      pending <= load || (pending && !commit);
    end
  end

  always_comb begin
    last = c == CW'(DIGIT_CYCLES - 1);
    c_n = last ? '0 : c + 1'b1;
    d_n = last ? d + 2'd1 : d;
    st_n = (st == ST_BLANK) ? ((c_n == CW'(BLANK_CYCLES)) ? ST_ON : ST_BLANK)
                            : ((c_n == '0) ? ST_BLANK : ST_ON);
    commit = last && d == 2'd3 && pending;
  end

  // Outputs are precomputed for the coming (c, d) so the flops present them in that very cycle
  always_comb begin
    nib = 4'(disp >> {d_n, 2'b00});
    sup = LZ_SUPPRESS != 0 && d_n != 2'd0 && (disp >> {d_n, 2'b00}) == 16'd0;
    on = st_n == ST_ON && !sup;
    an_n = on ? ~(4'b0001 << d_n) : AN_OFF;
    seg_n = on ? seg_dec : SEG_OFF;
    dp_n = on ? ~disp_dp[d_n] : 1'b1;
    fd_n = c_n == CW'(DIGIT_CYCLES - 1) && d_n == 2'd3;
  end
endmodule

// File: tb/tb_seven_seg_frame_driver.sv
// tb_seven_seg_frame_driver: directed loads with a frame scoreboard checked cycle by cycle
module tb_seven_seg_frame_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0;
  logic load = 1'b0;
  logic pending, dp, frame_done;
  logic [3:0] an;
  logic [6:0] seg;

  typedef struct {int fn; logic [15:0] v; logic [3:0] p;} exp_t;
  exp_t q[$];
  exp_t cur;
  int tests = 0, fails = 0, cyc = 0, t, f;
  bit chk = 0;
  logic [6:0] lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seven_seg_frame_driver dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
    .pending(pending), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_out(input logic [15:0] v, input logic [3:0] p, input int tt);
    int c = tt % 16;
    int d = tt / 16;
    logic [3:0] a = ~(4'b0001 << d);
    logic [15:0] hi = v >> (4 * d);
    logic [3:0] nib = v[4*d +: 4];
    if (c < 2 || (d != 0 && hi == 16'd0)) return 12'hFFF;
    return {a, lut[nib], ~p[d]};
  endfunction

  always @(negedge clk) if (!reset) begin
    t = cyc % 64;
    f = cyc / 64;
    if (t == 0) begin
      chk = 0;
      if (q.size() > 0 && q[0].fn == f) begin
        cur = q.pop_front();
        chk = 1;
      end
    end
    check($sformatf("frame_done f%0d t%0d", f, t), 32'(frame_done), 32'(t == 63));
    if (chk) check($sformatf("an/seg/dp f%0d t%0d", f, t), 32'({an, seg, dp}),
                   32'(exp_out(cur.v, cur.p, t)));
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pend(input int n, input logic e);
    at(n);
    check($sformatf("pending c%0d", n), 32'(pending), 32'(e));
  endtask

  task automatic ld(input int n, input logic [15:0] v, input logic [3:0] p);
    at(n);
    load = 1'b1;
    data_in = v;
    dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push(input int fn, input logic [15:0] v, input logic [3:0] p);
    q.push_back('{fn, v, p});
  endtask

  task automatic chk_reset_state(input string tag);
    check({tag, " an"}, 32'(an), 32'hF);
    check({tag, " seg"}, 32'(seg), 32'h7F);
    check({tag, " dp"}, 32'(dp), 32'h1);
    check({tag, " pending"}, 32'(pending), 32'h0);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    push(0, 16'h0000, 4'h0);
    push(1, 16'h1234, 4'h0);
    pend(4, 1'b0);
    ld(5, 16'h1234, 4'h0);
    pend(6, 1'b1);
    pend(63, 1'b1);
    pend(64, 1'b0);
    push(2, 16'h0005, 4'b0010);
    push(3, 16'h0000, 4'h0);
    ld(70, 16'h0005, 4'b0010);
    pend(127, 1'b1);
    pend(128, 1'b0);
    ld(140, 16'h0000, 4'h0);
    push(4, 16'h00F0, 4'hF);
    ld(200, 16'hAAAA, 4'h5);
    ld(230, 16'h00F0, 4'hF);
    pend(255, 1'b1);
    pend(256, 1'b0);
    push(5, 16'h00F0, 4'hF);
    push(6, 16'h8888, 4'b1000);
    ld(319, 16'h8888, 4'b1000);
    pend(320, 1'b1);
    pend(383, 1'b1);
    pend(384, 1'b0);
    push(7, 16'h1111, 4'h0);
    push(8, 16'h4321, 4'b0011);
    ld(400, 16'h1111, 4'h0);
    pend(447, 1'b1);
    ld(447, 16'h4321, 4'b0011);
    pend(448, 1'b1);
    pend(511, 1'b1);
    pend(512, 1'b0);
    ld(600, 16'h9999, 4'h0);
    push(0, 16'h0000, 4'h0);
    push(1, 16'h0000, 4'h0);
    at(612);
    @(posedge clk);
    #1;
    reset = 1'b1;
    load = 1'b1;
    data_in = 16'h7777;
    dp_in = 4'hF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load = 1'b0;
    @(negedge clk);
    chk_reset_state("mid-scan reset");
    pend(5, 1'b0);
    at(130);
    check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seven_seg_frame_driver.md
Name: seven_seg_frame_driver

Overview:
- Cathode/data side of the 4-digit multiplexed 7-segment display: the counterpart to the anode scan.
- Owns the digit scan. Drives the anodes together with the matching segment and decimal-point pattern.
- Inserts a dead-time blank at the start of every digit slot to prevent ghosting.
- Latches new display values via a load pulse and commits them only at frame boundaries, so a frame never mixes old and new data.

Parameters:
- DIGIT_CYCLES, 16: clock cycles per digit slot, blank window included; must be ≥ 2.
- BLANK_CYCLES, 2: dead-time cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- LZ_SUPPRESS, 1: 1 enables leading-zero suppression on digits 3..1.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: synchronous, active-high reset.
- data_in, input, 16: four hex nibbles; [3:0] is digit 0 (rightmost, an[0]).
- dp_in, input, 4: per-digit decimal point, active-high.
- load, input, 1: single-cycle strobe that captures data_in and dp_in into the pending register.
- pending, output, 1: high while captured data is awaiting commit.
- an, output, 4: anode enables, active-low.
- seg, output, 7: cathodes, active-low; seg[0]=a … seg[6]=g.
- dp, output, 1: decimal-point cathode, active-low.
- frame_done, output, 1: one-cycle pulse in the last cycle of the digit-3 slot.

Behaviour:
- Reset (synchronous, takes priority over all other activity, valid in any state):
  - slot counter = 0, digit index = 0, state = BLANK.
  - display and pending registers cleared, pending = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_done = 0.
- All outputs are driven from flops; there is no combinational path from any input to any output.
- Output timing: in the cycle where slot counter = c and digit index = d, the outputs reflect (c, d) and the display register.
- Scan:
  - c counts 0 → DIGIT_CYCLES-1.
  - At c = DIGIT_CYCLES-1, c wraps to 0 and d advances 0→1→2→3→0.
  - One frame = 4*DIGIT_CYCLES cycles (64 at defaults).
  - The first cycle after reset deasserts is c = 0, d = 0.
- Per-slot states:
  - BLANK (c < BLANK_CYCLES): an = 1111, seg = 1111111, dp = 1.
  - ON (c ≥ BLANK_CYCLES): an = 1 except bit d = 0; seg = hex decode of nibble d; dp = ~dp bit d.
- Hex decode (seg[6:0] = gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Digit k ∈ {3,2,1} is suppressed when nibbles k..3 are all zero.
  - A suppressed digit stays in BLANK output for its whole slot, with its dp forced off as well.
  - Digit 0 is never suppressed.
  - Timing is unchanged by suppression.
- Load/commit:
  - load = 1 captures data_in/dp_in into the pending register and sets pending.
  - A later load before commit overwrites; the last load wins.
  - Commit cycle = c = DIGIT_CYCLES-1, d = 3 (the frame_done cycle). If pending = 1 at the clock edge ending that cycle, the display register takes the pending value and pending clears.
  - New data is visible from slot 0 of the next frame.
- Simultaneous load and commit: the old pending value commits, the new data is captured, and pending stays 1 until the next frame boundary.
- load during reset is ignored.

Decomposition:
- Shared package holds:
  - the 16-entry segment decode constants;
  - localparams ST_BLANK/ST_ON;
  - blank patterns AN_OFF = 4'b1111 and SEG_OFF = 7'b1111111.
- One sub-module is natural: hex_to_seg (combinational 4→7 decode using the package constants), reused by other display blocks.
- Scan, suppression and load/commit logic stay in the top module.

Test Plan (defaults: DIGIT_CYCLES=16, BLANK_CYCLES=2):
1. Reset, then load 0x1234 with dp_in=0 at cycle 5 → pending=1 until the cycle-63 edge; frame_done high only at cycle 63. Next frame shows:
   - d0: an=1110, seg=0011001
   - d1: an=1101, seg=0110000
   - d2: an=1011, seg=0100100
   - d3: an=0111, seg=1111001
2. Any frame → the first 2 cycles of every slot show an=1111, seg=1111111, dp=1; cycles 2..15 show the ON pattern.
3. Load 0x0005 with dp_in=4'b0010 → digits 3..1 keep an bit = 1 and dp=1 for the whole frame; digit 0 shows seg=0010010. Load 0x0000 → only digit 0 lit, seg=1000000.
4. Load 0xAAAA then 0x00F0 within one frame → commit shows 0x00F0 only: d1 seg=0001110, d0 seg=1000000, d3/d2 suppressed; pending drops the cycle after frame_done.
5. Load 0x8888 exactly in the frame_done cycle → not shown next frame; pending stays 1 and commits at the following boundary.
6. Assert reset during the d=2 ON window → next cycle an=1111, seg=1111111, dp=1, pending=0, frame_done=0; after release, the scan restarts at c=0, d=0 and digit 0 shows "0".
